io_input_ctrl: RTL and testbench

IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

---
 rtl/io_input_ctrl_pkg.sv | 13 +
 rtl/io_input_ctrl_debounce.sv | 55 +++++
 rtl/io_input_ctrl.sv | 81 ++++++++
 tb/tb_io_input_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_input_ctrl_pkg.sv
// Shared definitions for the IO input controller: FSM encoding, data width
// and the default debounce length.
package io_input_ctrl_pkg;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 20;
  localparam int IO_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_RELEASE = 2'd1,
    ST_WAIT_PRESS   = 2'd2,
    ST_DONE         = 2'd3
  } io_state_e;
endpackage

// File: rtl/io_input_ctrl_debounce.sv
// Push-button front end: 2-flop synchronizer, counter debouncer and a
// registered rising-edge pulse on the debounced level.
module io_debounce
  import io_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; the final disagreeing cycle flips the level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign level_out  = stable_q;
  assign rise_pulse = rise_q;
endmodule

// File: rtl/io_input_ctrl.sv
// Switch-read controller: stalls the pipeline on an IO-input load and
// captures the switch bank on a fresh, debounced enter press.
module io_input_ctrl
  import io_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter_btn,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic                 io_read_req,
  output logic                 stall_req_io,
  output logic                 enter_pulse,
  output logic [IO_DATA_W-1:0] io_rdata,
  output logic                 io_valid,
  output io_state_e            dbg_state,
  output logic                 dbg_level
);
  // Handshake: io_read_req is a level held until satisfied; io_valid is a
  // one-cycle strobe with io_rdata, and stall_req_io drops in that cycle.

  logic                 btn_level;
  logic [IO_DATA_W-1:0] rdata_q, rdata_d;
  logic                 valid_q, valid_d;
  io_state_e            state_q, state_d;

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (enter_btn),
    .level_out (btn_level),
    .rise_pulse(enter_pulse)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (io_read_req) state_d = btn_level ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
      end
      ST_WAIT_RELEASE: begin
        if (!io_read_req)    state_d = ST_IDLE;
        else if (!btn_level) state_d = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS: begin
        if (!io_read_req) begin
          state_d = ST_IDLE;
        end else if (enter_pulse) begin
          state_d = ST_DONE;
          rdata_d = IO_DATA_W'(sw_in);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign stall_req_io = ((state_q == ST_IDLE) && io_read_req) ||
                        (state_q == ST_WAIT_RELEASE) || (state_q == ST_WAIT_PRESS);
  assign io_rdata     = rdata_q;
  assign io_valid     = valid_q;
  assign dbg_state    = state_q;
  assign dbg_level    = btn_level;
endmodule

// File: tb/tb_io_input_ctrl.sv
// Randomized and directed bench for io_input_ctrl against a behavioural model.
module tb_io_input_ctrl;
  import io_input_ctrl_pkg::*;

  localparam int N = 4;
  localparam int SW_W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            enter_btn = 1'b0;
  logic [SW_W-1:0] sw_in = '0;
  logic            io_read_req = 1'b0;
  logic            stall_req_io, enter_pulse, io_valid, dbg_level;
  logic [31:0]     io_rdata;
  io_state_e       dbg_state;

  io_input_ctrl #(.DEBOUNCE_CYCLES(N), .SW_WIDTH(SW_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enter_btn   (enter_btn),
    .sw_in       (sw_in),
    .io_read_req (io_read_req),
    .stall_req_io(stall_req_io),
    .enter_pulse (enter_pulse),
    .io_rdata    (io_rdata),
    .io_valid    (io_valid),
    .dbg_state   (dbg_state),
    .dbg_level   (dbg_level)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_valid = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: raw button history, accepted level, request bookkeeping
  bit          hist[$];
  logic        m_level = 1'b0, m_pulse = 1'b0;
  logic        m_busy = 1'b0, m_armed = 1'b0, m_done = 1'b0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = 1'b0; m_pulse = 1'b0;
      m_busy = 1'b0; m_armed = 1'b0; m_done = 1'b0;
      m_rdata = '0;
      hist = {};
      for (int i = 0; i < N + 2; i++) hist.push_back(1'b0);
    end else begin
      bit all_diff;
      logic new_level;
      // request side: a request is served by the first press that follows
      // a moment of the button being seen released while the request waits
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_busy) begin
        if (io_read_req) begin
          m_busy = 1'b1;
          m_armed = !m_level;
        end
      end else if (!io_read_req) begin
        m_busy = 1'b0;
      end else if (!m_armed) begin
        m_armed = !m_level;
      end else if (m_pulse) begin
        m_rdata = {16'h0, sw_in};
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      // button side: the level follows once the last N synchronized samples
      // (raw samples two edges old) all disagree with it
      hist.push_back(enter_btn);
      all_diff = 1'b1;
      for (int k = 0; k < N; k++)
        if (hist[hist.size() - 3 - k] == m_level) all_diff = 1'b0;
      new_level = all_diff ? !m_level : m_level;
      m_pulse = !m_level && new_level;
      m_level = new_level;
      if (hist.size() > 64) void'(hist.pop_front());
    end
  end

  // scoreboard compare every cycle
  always @(negedge clk) begin
    check("io_rdata", io_rdata, m_rdata);
    check("io_valid", 32'(io_valid), 32'(m_done));
    check("enter_pulse", 32'(enter_pulse), 32'(m_pulse));
    check("stall_req_io", 32'(stall_req_io), 32'(m_busy || (!m_done && io_read_req)));
    check("stable_level", 32'(dbg_level), 32'(m_level));
    if (enter_pulse) n_pulse++;
    if (io_valid) n_valid++;
  end

  // driver tasks
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (io_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int p0, v0;

    // reset state
    cyc(3);
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_strobes", {30'h0, io_valid, enter_pulse}, 32'h0);
    check("rst_stall_idle", 32'(stall_req_io), 32'd0);
    io_read_req = 1'b1;
    #1;
    check("rst_stall_follows_req", 32'(stall_req_io), 32'd1);
    io_read_req = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(2);

    // short glitch is rejected, long press yields one pulse
    p0 = n_pulse;
    enter_btn = 1'b1; cyc(3);
    enter_btn = 1'b0; cyc(10);
    check("glitch_pulses", 32'(n_pulse - p0), 32'd0);
    check("glitch_level", 32'(dbg_level), 32'd0);
    p0 = n_pulse;
    enter_btn = 1'b1; cyc(10);
    check("press_level", 32'(dbg_level), 32'd1);
    enter_btn = 1'b0; cyc(12);
    check("press_pulses", 32'(n_pulse - p0), 32'd1);

    // basic capture
    sw_in = 16'hA5C3;
    io_read_req = 1'b1;
    #1;
    check("stall_same_cycle", 32'(stall_req_io), 32'd1);
    enter_btn = 1'b1;
    wait_valid("cap_a5c3");
    check("cap_a5c3_rdata", io_rdata, 32'h0000A5C3);
    check("cap_a5c3_stall", 32'(stall_req_io), 32'd0);
    #1 io_read_req = 1'b0;
    cyc(1);
    check("cap_a5c3_valid_one", 32'(io_valid), 32'd0);
    enter_btn = 1'b0; cyc(10);

    // press already held when the request arrives is not consumed
    enter_btn = 1'b1; cyc(10);
    v0 = n_valid;
    sw_in = 16'h0001;
    io_read_req = 1'b1;
    cyc(10);
    check("held_state", 32'(dbg_state), 32'(ST_WAIT_RELEASE));
    check("held_no_cap", 32'(n_valid - v0), 32'd0);
    enter_btn = 1'b0; cyc(10);
    enter_btn = 1'b1;
    wait_valid("cap_0001");
    check("cap_0001_rdata", io_rdata, 32'h00000001);
    #1 io_read_req = 1'b0;
    enter_btn = 1'b0; cyc(10);

    // flush while waiting for a press
    io_read_req = 1'b1; cyc(3);
    check("flush_wait_state", 32'(dbg_state), 32'(ST_WAIT_PRESS));
    io_read_req = 1'b0; cyc(1);
    check("flush_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    p0 = n_pulse; v0 = n_valid;
    sw_in = 16'hFFFF;
    enter_btn = 1'b1; cyc(10);
    enter_btn = 1'b0; cyc(10);
    check("flush_pulse", 32'(n_pulse - p0), 32'd1);
    check("flush_no_valid", 32'(n_valid - v0), 32'd0);
    check("flush_rdata_kept", io_rdata, 32'h00000001);

    // asynchronous reset mid-wait
    sw_in = 16'h1234;
    io_read_req = 1'b1;
    enter_btn = 1'b1;
    wait_valid("cap_1234");
    #1 io_read_req = 1'b0;
    enter_btn = 1'b0; cyc(10);
    io_read_req = 1'b1; cyc(3);
    check("arst_pre_state", 32'(dbg_state), 32'(ST_WAIT_PRESS));
    check("arst_pre_rdata", io_rdata, 32'h00001234);
    #1 rst = 1'b1;
    #1;
    check("arst_rdata", io_rdata, 32'h0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("arst_strobes", {30'h0, io_valid, enter_pulse}, 32'h0);
    check("arst_stall", 32'(stall_req_io), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    io_read_req = 1'b0;
    cyc(3);

    // back-to-back requests with io_read_req held throughout
    io_read_req = 1'b1;
    v0 = n_valid;
    sw_in = 16'h0F0F;
    enter_btn = 1'b1;
    wait_valid("b2b_0f0f");
    check("b2b_0f0f_rdata", io_rdata, 32'h00000F0F);
    #1 enter_btn = 1'b0;
    cyc(8);
    sw_in = 16'hF0F0;
    enter_btn = 1'b1;
    wait_valid("b2b_f0f0");
    check("b2b_f0f0_rdata", io_rdata, 32'h0000F0F0);
    #1 io_read_req = 1'b0;
    enter_btn = 1'b0;
    cyc(10);
    check("b2b_valid_count", 32'(n_valid - v0), 32'd2);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      enter_btn = 1'($urandom_range(0, 1));
      sw_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) io_read_req = !io_read_req;
      cyc($urandom_range(1, 10));
    end
    io_read_req = 1'b0;
    enter_btn = 1'b0;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
